// File: rtl/uart_lattice_pkg.sv
// Shared definitions for the Lattice UART APB scheduler: register map,
// divisor-latch access bit and the scheduler state encoding.
package uart_lattice_pkg;

    localparam logic [5:0] UART_THR = 6'h00;
    localparam logic [5:0] UART_RBR = 6'h00;
    localparam logic [5:0] UART_IER = 6'h04;
    localparam logic [5:0] UART_FCR = 6'h08;
    localparam logic [5:0] UART_LCR = 6'h0C;
    localparam logic [5:0] UART_LSR = 6'h14;
    localparam logic [5:0] UART_DLL = 6'h1C;
    localparam logic [5:0] UART_DLM = 6'h20;

    localparam logic [7:0] LCR_DLAB = 8'h80;

    localparam logic [2:0] INIT_LAST = 3'd5;

    typedef enum logic [2:0] {
        INIT_SETUP,
        INIT_ACCESS,
        IDLE,
        SETUP,
        ACCESS,
        RESPOND
    } sched_state_e;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } apb_wr_t;

endpackage

// File: rtl/uart_lattice_apb_scheduler.sv
// Two-requester APB arbiter in front of a Lattice UART: runs a fixed init
// write sequence after reset, then round-robins host accesses with a timeout.
module uart_lattice_apb_scheduler
    import uart_lattice_pkg::*;
#(
    parameter logic [15:0] BAUD_DIV       = 16'd27,
    parameter logic [7:0]  LCR_VAL        = 8'h03,
    parameter logic [7:0]  FCR_VAL        = 8'h07,
    parameter logic [7:0]  IER_VAL        = 8'h01,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        resn,
    input  logic        s0_apb_psel,
    input  logic        s0_apb_penable,
    input  logic        s0_apb_pwrite,
    input  logic [5:0]  s0_apb_paddr,
    input  logic [31:0] s0_apb_pwdata,
    output logic        s0_apb_pready,
    output logic        s0_apb_pslverr,
    output logic [31:0] s0_apb_prdata,
    input  logic        s1_apb_psel,
    input  logic        s1_apb_penable,
    input  logic        s1_apb_pwrite,
    input  logic [5:0]  s1_apb_paddr,
    input  logic [31:0] s1_apb_pwdata,
    output logic        s1_apb_pready,
    output logic        s1_apb_pslverr,
    output logic [31:0] s1_apb_prdata,
    output logic        m_apb_psel,
    output logic        m_apb_penable,
    output logic        m_apb_pwrite,
    output logic [5:0]  m_apb_paddr,
    output logic [31:0] m_apb_pwdata,
    input  logic        m_apb_pready,
    input  logic        m_apb_pslverr,
    input  logic [31:0] m_apb_prdata,
    output logic        init_done,
    output logic        timeout_err
);

    localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT_CYCLES);

    function automatic apb_wr_t init_entry(input logic [2:0] idx);
        apb_wr_t e;
        e.addr = UART_IER;
        e.data = {24'd0, IER_VAL};
        case (idx)
            3'd0: begin e.addr = UART_LCR; e.data = {24'd0, LCR_VAL | LCR_DLAB}; end
            3'd1: begin e.addr = UART_DLL; e.data = {24'd0, BAUD_DIV[7:0]}; end
            3'd2: begin e.addr = UART_DLM; e.data = {24'd0, BAUD_DIV[15:8]}; end
            3'd3: begin e.addr = UART_LCR; e.data = {24'd0, LCR_VAL}; end
            3'd4: begin e.addr = UART_FCR; e.data = {24'd0, FCR_VAL}; end
            default: ;
        endcase
        return e;
    endfunction

    sched_state_e state_reg, state_next;
    logic [2:0]  idx_reg, idx_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic        grant_reg, grant_next;
    logic        last_grant_reg, last_grant_next;
    logic        init_done_reg, init_done_next;
    logic        timeout_hit;
    logic [31:0] rsp_data;
    logic        rsp_err;
    apb_wr_t     init_wr;

    logic        m_psel_reg, m_penable_reg, m_pwrite_reg;
    logic [5:0]  m_paddr_reg;
    logic [31:0] m_pwdata_reg;
    logic        s0_pready_reg, s0_pslverr_reg, s1_pready_reg, s1_pslverr_reg;
    logic [31:0] s0_prdata_reg, s1_prdata_reg;
    logic        timeout_err_reg;

    // Requester penable carries no information for this arbiter; pending is psel alone.
    logic unused_penable;
    assign unused_penable = s0_apb_penable ^ s1_apb_penable;

    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        cnt_next        = '0;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        init_done_next  = init_done_reg;
        rsp_data        = '0;
        rsp_err         = 1'b0;
        timeout_hit     = (state_reg == INIT_ACCESS || state_reg == ACCESS) && !m_apb_pready
                          && (({1'b0, cnt_reg} + 9'd1) >= TIMEOUT_LIM);
        case (state_reg)
            // First cycle after reset has psel still low, so wait for it to be presented.
            INIT_SETUP: if (m_psel_reg) state_next = INIT_ACCESS;
            INIT_ACCESS: begin
                if (m_apb_pready || timeout_hit) begin
                    if (idx_reg == INIT_LAST) begin
                        state_next     = IDLE;
                        init_done_next = 1'b1;
                    end else begin
                        idx_next   = idx_reg + 3'd1;
                        state_next = INIT_SETUP;
                    end
                end else begin
                    cnt_next = (cnt_reg == 8'hFF) ? cnt_reg : cnt_reg + 8'd1;
                end
            end
            IDLE: begin
                if (s0_apb_psel && s1_apb_psel) begin
                    grant_next = ~last_grant_reg;
                    state_next = SETUP;
                end else if (s0_apb_psel) begin
                    grant_next = 1'b0;
                    state_next = SETUP;
                end else if (s1_apb_psel) begin
                    grant_next = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: state_next = ACCESS;
            ACCESS: begin
                if (m_apb_pready) begin
                    rsp_data   = m_apb_prdata;
                    rsp_err    = m_apb_pslverr;
                    state_next = RESPOND;
                end else if (timeout_hit) begin
                    rsp_err    = 1'b1;
                    state_next = RESPOND;
                end else begin
                    cnt_next = (cnt_reg == 8'hFF) ? cnt_reg : cnt_reg + 8'd1;
                end
            end
            RESPOND: begin
                last_grant_next = grant_reg;
                state_next      = IDLE;
            end
            default: state_next = INIT_SETUP;
        endcase
    end

    assign init_wr = init_entry(idx_next);

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            state_reg       <= INIT_SETUP;
            idx_reg         <= '0;
            cnt_reg         <= '0;
            grant_reg       <= 1'b0;
            last_grant_reg  <= 1'b1;
            init_done_reg   <= 1'b0;
            m_psel_reg      <= 1'b0;
            m_penable_reg   <= 1'b0;
            m_pwrite_reg    <= 1'b0;
            m_paddr_reg     <= '0;
            m_pwdata_reg    <= '0;
            s0_pready_reg   <= 1'b0;
            s0_pslverr_reg  <= 1'b0;
            s0_prdata_reg   <= '0;
            s1_pready_reg   <= 1'b0;
            s1_pslverr_reg  <= 1'b0;
            s1_prdata_reg   <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            idx_reg         <= idx_next;
            cnt_reg         <= cnt_next;
            grant_reg       <= grant_next;
            last_grant_reg  <= last_grant_next;
            init_done_reg   <= init_done_next;
            timeout_err_reg <= timeout_hit;
            // Bus outputs are registered off the next state so they line up with it.
            m_psel_reg    <= (state_next == INIT_SETUP) || (state_next == INIT_ACCESS)
                             || (state_next == SETUP) || (state_next == ACCESS);
            m_penable_reg <= (state_next == INIT_ACCESS) || (state_next == ACCESS);
            if (state_next == INIT_SETUP) begin
                m_pwrite_reg <= 1'b1;
                m_paddr_reg  <= init_wr.addr;
                m_pwdata_reg <= init_wr.data;
            end else if (state_reg == IDLE && state_next == SETUP) begin
                m_pwrite_reg <= grant_next ? s1_apb_pwrite : s0_apb_pwrite;
                m_paddr_reg  <= grant_next ? s1_apb_paddr  : s0_apb_paddr;
                m_pwdata_reg <= grant_next ? s1_apb_pwdata : s0_apb_pwdata;
            end
            s0_pready_reg  <= (state_next == RESPOND) && !grant_next;
            s0_pslverr_reg <= (state_next == RESPOND) && !grant_next && rsp_err;
            s0_prdata_reg  <= ((state_next == RESPOND) && !grant_next) ? rsp_data : '0;
            s1_pready_reg  <= (state_next == RESPOND) && grant_next;
            s1_pslverr_reg <= (state_next == RESPOND) && grant_next && rsp_err;
            s1_prdata_reg  <= ((state_next == RESPOND) && grant_next) ? rsp_data : '0;
        end
    end

    assign m_apb_psel     = m_psel_reg;
    assign m_apb_penable  = m_penable_reg;
    assign m_apb_pwrite   = m_pwrite_reg;
    assign m_apb_paddr    = m_paddr_reg;
    assign m_apb_pwdata   = m_pwdata_reg;
    assign s0_apb_pready  = s0_pready_reg;
    assign s0_apb_pslverr = s0_pslverr_reg;
    assign s0_apb_prdata  = s0_prdata_reg;
    assign s1_apb_pready  = s1_pready_reg;
    assign s1_apb_pslverr = s1_pslverr_reg;
    assign s1_apb_prdata  = s1_prdata_reg;
    assign init_done      = init_done_reg;
    assign timeout_err    = timeout_err_reg;

endmodule

// File: tb/tb_uart_lattice_apb_scheduler.sv
// Directed testbench for the UART APB scheduler: init sequence, arbitration,
// read latency, timeout and reset abort.
module tb_uart_lattice_apb_scheduler;

    logic        clk;
    logic        resn;
    logic        s0_apb_psel, s0_apb_penable, s0_apb_pwrite;
    logic [5:0]  s0_apb_paddr;
    logic [31:0] s0_apb_pwdata;
    logic        s0_apb_pready, s0_apb_pslverr;
    logic [31:0] s0_apb_prdata;
    logic        s1_apb_psel, s1_apb_penable, s1_apb_pwrite;
    logic [5:0]  s1_apb_paddr;
    logic [31:0] s1_apb_pwdata;
    logic        s1_apb_pready, s1_apb_pslverr;
    logic [31:0] s1_apb_prdata;
    logic        m_apb_psel, m_apb_penable, m_apb_pwrite;
    logic [5:0]  m_apb_paddr;
    logic [31:0] m_apb_pwdata;
    logic        m_apb_pready, m_apb_pslverr;
    logic [31:0] m_apb_prdata;
    logic        init_done, timeout_err;

    logic        slave_en;
    logic [31:0] slave_rdata;

    int checks = 0;
    int errors = 0;
    int to_pulses = 0;
    int overlap = 0;
    int access_cycles = 0;
    logic [5:0]  mon_addr[$];
    logic [31:0] mon_data[$];
    logic        mon_write[$];

    uart_lattice_apb_scheduler dut (
        .clk(clk), .resn(resn),
        .s0_apb_psel(s0_apb_psel), .s0_apb_penable(s0_apb_penable), .s0_apb_pwrite(s0_apb_pwrite),
        .s0_apb_paddr(s0_apb_paddr), .s0_apb_pwdata(s0_apb_pwdata),
        .s0_apb_pready(s0_apb_pready), .s0_apb_pslverr(s0_apb_pslverr), .s0_apb_prdata(s0_apb_prdata),
        .s1_apb_psel(s1_apb_psel), .s1_apb_penable(s1_apb_penable), .s1_apb_pwrite(s1_apb_pwrite),
        .s1_apb_paddr(s1_apb_paddr), .s1_apb_pwdata(s1_apb_pwdata),
        .s1_apb_pready(s1_apb_pready), .s1_apb_pslverr(s1_apb_pslverr), .s1_apb_prdata(s1_apb_prdata),
        .m_apb_psel(m_apb_psel), .m_apb_penable(m_apb_penable), .m_apb_pwrite(m_apb_pwrite),
        .m_apb_paddr(m_apb_paddr), .m_apb_pwdata(m_apb_pwdata),
        .m_apb_pready(m_apb_pready), .m_apb_pslverr(m_apb_pslverr), .m_apb_prdata(m_apb_prdata),
        .init_done(init_done), .timeout_err(timeout_err)
    );

    // Zero-wait-state slave when enabled, silent otherwise.
    assign m_apb_pready  = slave_en & m_apb_psel & m_apb_penable;
    assign m_apb_prdata  = slave_rdata;
    assign m_apb_pslverr = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (m_apb_psel && m_apb_penable && m_apb_pready) begin
            mon_addr.push_back(m_apb_paddr);
            mon_data.push_back(m_apb_pwdata);
            mon_write.push_back(m_apb_pwrite);
            $display("xfer addr=%h data=%h write=%0b", m_apb_paddr, m_apb_pwdata, m_apb_pwrite);
        end
        if (timeout_err) to_pulses++;
        if (s0_apb_pready && s1_apb_pready) overlap++;
        if (m_apb_penable) access_cycles++;
    end

    task automatic test_reset();
        checks++;
        if ({m_apb_psel, m_apb_penable, m_apb_pwrite, m_apb_paddr, m_apb_pwdata} !== 41'd0) begin
            errors++;
            $display("FAIL reset_m_bus: got %h want 0",
                     {m_apb_psel, m_apb_penable, m_apb_pwrite, m_apb_paddr, m_apb_pwdata});
        end
        checks++;
        if ({s0_apb_pready, s0_apb_pslverr, s0_apb_prdata, s1_apb_pready, s1_apb_pslverr, s1_apb_prdata} !== 68'd0) begin
            errors++;
            $display("FAIL reset_s_resp: got nonzero requester response want 0");
        end
        checks++;
        if ({init_done, timeout_err} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00", {init_done, timeout_err});
        end
    endtask

    task automatic test_init();
        logic [5:0]  exp_a [6];
        logic [31:0] exp_d [6];
        int base;
        bit done;
        exp_a = '{6'h0C, 6'h1C, 6'h20, 6'h0C, 6'h08, 6'h04};
        exp_d = '{32'h83, 32'h1B, 32'h00, 32'h03, 32'h07, 32'h01};
        base = mon_addr.size();
        @(negedge clk);
        resn = 1'b1;
        @(negedge clk);
        checks++;
        if (init_done !== 1'b0) begin
            errors++;
            $display("FAIL init_done_early: got %0b want 0", init_done);
        end
        done = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (init_done) begin done = 1'b1; break; end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL init_done_timeout: got 0 want 1 within 50 cycles");
        end
        checks++;
        if (mon_addr.size() - base != 6) begin
            errors++;
            $display("FAIL init_count: got %0d writes want 6", mon_addr.size() - base);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (base + i >= mon_addr.size()) begin
                errors++;
                $display("FAIL init_write%0d: got none want %h=%h", i, exp_a[i], exp_d[i]);
            end else if (mon_addr[base+i] !== exp_a[i] || mon_data[base+i] !== exp_d[i] || mon_write[base+i] !== 1'b1) begin
                errors++;
                $display("FAIL init_write%0d: got %h=%h w%0b want %h=%h w1", i,
                         mon_addr[base+i], mon_data[base+i], mon_write[base+i], exp_a[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_round_robin();
        int base, got, expg, ov0;
        logic [5:0]  ea;
        logic [31:0] ed;
        ov0 = overlap;
        for (int i = 0; i < 4; i++) begin
            base = mon_addr.size();
            @(negedge clk);
            s0_apb_psel = 1'b1; s0_apb_pwrite = 1'b1; s0_apb_paddr = 6'h00; s0_apb_pwdata = 32'hA0 + 32'(i);
            s1_apb_psel = 1'b1; s1_apb_pwrite = 1'b1; s1_apb_paddr = 6'h04; s1_apb_pwdata = 32'hB0 + 32'(i);
            got = -1;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (s0_apb_pready || s1_apb_pready) begin
                    got = s1_apb_pready ? 1 : 0;
                    break;
                end
            end
            expg = i % 2;
            ea = (expg == 1) ? 6'h04 : 6'h00;
            ed = (expg == 1) ? 32'hB0 + 32'(i) : 32'hA0 + 32'(i);
            $display("rr round %0d grant=%0d", i, got);
            checks++;
            if (got != expg) begin
                errors++;
                $display("FAIL rr_grant%0d: got %0d want %0d", i, got, expg);
            end
            checks++;
            if (mon_addr.size() != base + 1) begin
                errors++;
                $display("FAIL rr_xfer%0d: got %0d transfers want 1", i, mon_addr.size() - base);
            end else if (mon_addr[base] !== ea || mon_data[base] !== ed) begin
                errors++;
                $display("FAIL rr_xfer%0d: got %h=%h want %h=%h", i, mon_addr[base], mon_data[base], ea, ed);
            end
            s0_apb_psel = 1'b0;
            s1_apb_psel = 1'b0;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (overlap != ov0) begin
            errors++;
            $display("FAIL rr_overlap: got %0d cycles with both pready want 0", overlap - ov0);
        end
    endtask

    task automatic test_read_latency();
        int lat, base;
        base = mon_addr.size();
        slave_rdata = 32'h60;
        @(negedge clk);
        s0_apb_psel = 1'b1; s0_apb_pwrite = 1'b0; s0_apb_paddr = 6'h14; s0_apb_pwdata = 32'h0;
        lat = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (s0_apb_pready) begin lat = c; break; end
        end
        // psel cycle is cycle 1, so pready in cycle 4 is three edges later
        $display("read lsr prdata=%h latency_cycles=%0d", s0_apb_prdata, lat + 1);
        checks++;
        if (lat + 1 != 4) begin
            errors++;
            $display("FAIL read_latency: got %0d want 4", lat + 1);
        end
        checks++;
        if (s0_apb_prdata !== 32'h60 || s0_apb_pslverr !== 1'b0) begin
            errors++;
            $display("FAIL read_data: got %h err %0b want 00000060 err 0", s0_apb_prdata, s0_apb_pslverr);
        end
        checks++;
        if (s1_apb_pready !== 1'b0 || s1_apb_prdata !== 32'h0) begin
            errors++;
            $display("FAIL read_other_idle: got pready %0b prdata %h want 0 0", s1_apb_pready, s1_apb_prdata);
        end
        checks++;
        if (mon_addr.size() != base + 1) begin
            errors++;
            $display("FAIL read_xfer: got %0d transfers want 1", mon_addr.size() - base);
        end else if (mon_addr[base] !== 6'h14 || mon_write[base] !== 1'b0) begin
            errors++;
            $display("FAIL read_xfer: got %h w%0b want 14 w0", mon_addr[base], mon_write[base]);
        end
        s0_apb_psel = 1'b0;
        @(negedge clk);
        checks++;
        if (s0_apb_pready !== 1'b0 || s0_apb_prdata !== 32'h0) begin
            errors++;
            $display("FAIL read_pulse: got pready %0b prdata %h want 0 0", s0_apb_pready, s0_apb_prdata);
        end
    endtask

    task automatic test_timeout();
        int p0, a0;
        bit got;
        slave_en = 1'b0;
        slave_rdata = 32'hDEADBEEF;
        p0 = to_pulses;
        a0 = access_cycles;
        @(negedge clk);
        s1_apb_psel = 1'b1; s1_apb_pwrite = 1'b1; s1_apb_paddr = 6'h00; s1_apb_pwdata = 32'h55;
        got = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (s1_apb_pready) begin got = 1'b1; break; end
        end
        $display("timeout resp pready=%0b err=%0b prdata=%h", s1_apb_pready, s1_apb_pslverr, s1_apb_prdata);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL timeout_resp: got no pready want pready within 400 cycles");
        end
        checks++;
        if (s1_apb_pslverr !== 1'b1 || s1_apb_prdata !== 32'h0) begin
            errors++;
            $display("FAIL timeout_data: got err %0b prdata %h want err 1 prdata 0", s1_apb_pslverr, s1_apb_prdata);
        end
        checks++;
        if (timeout_err !== 1'b1 || s0_apb_pready !== 1'b0) begin
            errors++;
            $display("FAIL timeout_flag: got timeout_err %0b s0_pready %0b want 1 0", timeout_err, s0_apb_pready);
        end
        s1_apb_psel = 1'b0;
        slave_en = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (access_cycles - a0 != 255) begin
            errors++;
            $display("FAIL timeout_len: got %0d access cycles want 255", access_cycles - a0);
        end
        checks++;
        if (to_pulses - p0 != 1) begin
            errors++;
            $display("FAIL timeout_pulse: got %0d cycles want 1", to_pulses - p0);
        end
    endtask

    task automatic test_reset_mid_transfer();
        int base;
        bit seen, done;
        slave_en = 1'b0;
        @(negedge clk);
        s1_apb_psel = 1'b1; s1_apb_pwrite = 1'b1; s1_apb_paddr = 6'h00; s1_apb_pwdata = 32'h77;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (m_apb_penable) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL abort_access: got no access phase want one within 10 cycles");
        end
        repeat (3) @(negedge clk);
        #2 resn = 1'b0;
        #1;
        $display("reset asserted mid-access psel=%0b penable=%0b", m_apb_psel, m_apb_penable);
        checks++;
        if ({m_apb_psel, m_apb_penable, m_apb_pwrite, m_apb_paddr, m_apb_pwdata} !== 41'd0) begin
            errors++;
            $display("FAIL abort_m_bus: got %h want 0",
                     {m_apb_psel, m_apb_penable, m_apb_pwrite, m_apb_paddr, m_apb_pwdata});
        end
        checks++;
        if ({s0_apb_pready, s1_apb_pready, s1_apb_pslverr, s1_apb_prdata, init_done, timeout_err} !== 37'd0) begin
            errors++;
            $display("FAIL abort_flags: got nonzero requester/status outputs want 0");
        end
        s1_apb_psel = 1'b0;
        slave_en = 1'b1;
        base = mon_addr.size();
        @(negedge clk);
        resn = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (init_done) begin done = 1'b1; break; end
        end
        checks++;
        if (!done || mon_addr.size() - base != 6) begin
            errors++;
            $display("FAIL reinit_count: got done %0b writes %0d want 1 6", done, mon_addr.size() - base);
        end
        checks++;
        if (mon_addr.size() <= base) begin
            errors++;
            $display("FAIL reinit_first: got none want 0c=00000083");
        end else if (mon_addr[base] !== 6'h0C || mon_data[base] !== 32'h83) begin
            errors++;
            $display("FAIL reinit_first: got %h=%h want 0c=00000083", mon_addr[base], mon_data[base]);
        end
    endtask

    initial begin
        resn = 1'b0;
        slave_en = 1'b1;
        slave_rdata = 32'h0;
        s0_apb_psel = 1'b0; s0_apb_penable = 1'b0; s0_apb_pwrite = 1'b0; s0_apb_paddr = '0; s0_apb_pwdata = '0;
        s1_apb_psel = 1'b0; s1_apb_penable = 1'b0; s1_apb_pwrite = 1'b0; s1_apb_paddr = '0; s1_apb_pwdata = '0;
        #12;
        test_reset();
        test_init();
        test_round_robin();
        test_read_latency();
        test_timeout();
        test_reset_mid_transfer();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_lattice_apb_scheduler.md
UART_LATTICE_APB_SCHEDULER -- requirements
Module: uart_lattice_apb_scheduler

Interface
REQ-001 Parameter BAUD_DIV, default 16'd27: UART divisor latch value written at init.
REQ-002 Parameter LCR_VAL, default 8'h03: line control value (8N1).
REQ-003 Parameter FCR_VAL, default 8'h07: FIFO control value (enable, clear RX/TX).
REQ-004 Parameter IER_VAL, default 8'h01: interrupt enable value (RX data available).
REQ-005 Parameter TIMEOUT_CYCLES, default 255: maximum pready wait per transfer.
REQ-006 Ports clk (in, 1) and resn (in, 1); one clock; reset is asynchronous and active-low.
REQ-007 Ports s0_apb_psel, s0_apb_penable, s0_apb_pwrite (in, 1 each): requester 0 (UART data driver) control.
REQ-008 Ports s0_apb_paddr (in, 6), s0_apb_pwdata (in, 32): requester 0 address and write data.
REQ-009 Ports s0_apb_pready, s0_apb_pslverr (out, 1 each), s0_apb_prdata (out, 32): requester 0 response.
REQ-010 Ports s1_apb_* (same names, directions and widths as REQ-007..009): requester 1 (register-file host access).
REQ-011 Ports m_apb_psel, m_apb_penable, m_apb_pwrite (out, 1 each), m_apb_paddr (out, 6), m_apb_pwdata (out, 32): to Lattice UART IP.
REQ-012 Ports m_apb_pready, m_apb_pslverr (in, 1 each), m_apb_prdata (in, 32): from Lattice UART IP.
REQ-013 Ports init_done (out, 1): init sequence complete; timeout_err (out, 1): one-cycle pulse per timed-out transfer.

Function
REQ-014 FSM states: INIT_SETUP, INIT_ACCESS, IDLE, SETUP, ACCESS, RESPOND.
REQ-015 Init writes, in order: LCR 0x0C=LCR_VAL|0x80; DLL 0x1C=BAUD_DIV[7:0]; DLM 0x20=BAUD_DIV[15:8]; LCR 0x0C=LCR_VAL; FCR 0x08=FCR_VAL; IER 0x04=IER_VAL.
REQ-016 Each init write: INIT_SETUP one cycle (psel=1, penable=0), INIT_ACCESS with penable=1 until m_apb_pready or timeout; 3-bit index increments; after index 5 completes -> IDLE, init_done=1 (sticky until reset).
REQ-017 Init continues to the next entry on timeout or pslverr; timeout_err pulses.
REQ-018 No requester granted before init_done=1; requester s*_apb_pready stays 0 meanwhile.
REQ-019 IDLE: a requester is pending when its psel=1; capture pending requester's paddr/pwrite/pwdata into registers, record grant, -> SETUP next cycle.
REQ-020 Both pending same cycle: grant the one not served last; last_grant resets to 1 so requester 0 wins first.
REQ-021 SETUP: m_apb_psel=1, m_apb_penable=0, m_apb_* driven from captured registers; -> ACCESS.
REQ-022 ACCESS: m_apb_psel=1, m_apb_penable=1; on m_apb_pready=1 capture prdata/pslverr, deassert psel/penable next cycle, -> RESPOND.
REQ-023 ACCESS timeout: counter (8-bit, saturating) reaches TIMEOUT_CYCLES without pready -> RESPOND with pslverr=1, prdata=0, timeout_err pulse.
REQ-024 RESPOND: granted requester's pready=1 for exactly one cycle with captured prdata/pslverr; -> IDLE; last_grant updated.
REQ-025 Non-granted requester: pready=0, pslverr=0, prdata=0 at all times.
REQ-026 Min latency requester psel sampled -> pready: 4 cycles (IDLE, SETUP, ACCESS w/ immediate pready, RESPOND).
REQ-027 m_apb_* outputs registered; m_apb_pwdata/paddr stable from SETUP through end of ACCESS.
REQ-028 Requester deasserting psel mid-transfer: transfer on m_apb completes; response discarded except pready pulse.

Reset
REQ-029 resn=0 asynchronously: state=INIT_SETUP, index=0, all m_apb_* and s*_apb_* outputs 0, init_done=0, timeout_err=0, last_grant=1, timeout counter=0.
REQ-030 Reset mid-transfer aborts it; init sequence restarts from entry 0 after release.

Structure
REQ-031 Register offsets (THR/RBR 0x00, IER 0x04, FCR 0x08, LCR 0x0C, LSR 0x14, DLL 0x1C, DLM 0x20), DLAB bit and FSM state enum in shared package uart_lattice_pkg.
REQ-032 Single module; no sub-module; init table a combinational function of index.

Verification
REQ-033 Reset release, slave pready same cycle as penable -> six writes 0x0C=0x83, 0x1C=0x1B, 0x20=0x00, 0x0C=0x03, 0x08=0x07, 0x04=0x01; then init_done=1.
REQ-034 After init, s0 read 0x14, slave returns 0x60 -> s0_apb_prdata=0x60, s0_apb_pready one cycle, 4 cycles after psel.
REQ-035 s0 and s1 request same cycle, repeated 4 times -> grants alternate 0,1,0,1; s1 pready never asserted during s0 transfer.
REQ-036 Slave never asserts pready -> after 255 ACCESS cycles requester gets pready=1, pslverr=1, prdata=0; timeout_err one-cycle pulse.
REQ-037 resn low during ACCESS of s1 write -> all outputs 0 immediately; after release init restarts at 0x0C=0x83.
